// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack port, stalls upstream while busy,
// and hands a registered result to write-back. Flags misaligned 64-bit accesses and timeouts.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] alu_result,
  input  logic [63:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        byte_op,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  input  logic        err_clr,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        mem_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_byte_q, mem_byte_d;
  logic [63:0]       mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic [4:0]        cap_rd_q, cap_rd_d;
  logic              cap_reg_write_q, cap_reg_write_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [63:0]       wb_data_q, wb_data_d;
  logic              mem_err_q, mem_err_d;
  logic              err_set;
  logic              is_mem_op;
  logic              misaligned;

  assign is_mem_op  = mem_read | mem_write;
  assign misaligned = ~byte_op & (alu_result[2:0] != 3'b000);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_byte_d      = mem_byte_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    cap_rd_d        = cap_rd_q;
    cap_reg_write_d = cap_reg_write_q;
    wb_valid_d      = 1'b0;
    wb_reg_write_d  = wb_reg_write_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    err_set         = 1'b0;

    case (state_q)
      StIdle: begin
        if (ex_valid) begin
          if (!is_mem_op) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = alu_result;
            wb_rd_d        = rd;
            wb_reg_write_d = reg_write;
          end else if (misaligned) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = rd;
            wb_reg_write_d = 1'b0;
            err_set        = 1'b1;
          end else begin
            mem_addr_d      = alu_result;
            mem_wdata_d     = store_data;
            mem_we_d        = mem_write;
            mem_byte_d      = byte_op;
            cap_rd_d        = rd;
            cap_reg_write_d = reg_write;
            mem_req_d       = 1'b1;
            cnt_d           = '0;
            state_d         = StBusy;
          end
        end
      end
      StBusy: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = cap_rd_q;
          if (!mem_we_q) begin
            wb_data_d      = mem_byte_q ? {56'b0, mem_rdata[7:0]} : mem_rdata;
            wb_reg_write_d = cap_reg_write_q;
          end else begin
            wb_reg_write_d = 1'b0;
          end
          state_d = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          mem_req_d      = 1'b0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = cap_rd_q;
          wb_reg_write_d = 1'b0;
          err_set        = 1'b1;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_set) begin
      mem_err_d = 1'b1;
    end else if (err_clr) begin
      mem_err_d = 1'b0;
    end else begin
      mem_err_d = mem_err_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_byte_q      <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      cap_rd_q        <= '0;
      cap_reg_write_q <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      mem_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_byte_q      <= mem_byte_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      cap_rd_q        <= cap_rd_d;
      cap_reg_write_q <= cap_reg_write_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      mem_err_q       <= mem_err_d;
    end
  end

  assign stall        = (state_q == StBusy);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_byte     = mem_byte_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, misalign, timeout, reset abort.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic        byte_op;
  logic        reg_write;
  logic [4:0]  rd;
  logic        err_clr;
  logic        mem_req;
  logic        mem_we;
  logic        mem_byte;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write), .byte_op(byte_op),
    .reg_write(reg_write), .rd(rd), .err_clr(err_clr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; mem_read = 0; mem_write = 0; byte_op = 0; reg_write = 0;
    rd = 0; alu_result = 0; store_data = 0; err_clr = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] sd, input logic rdq,
                       input logic wrq, input logic bq, input logic rw, input logic [4:0] r);
    ex_valid = 1; alu_result = a; store_data = sd; mem_read = rdq; mem_write = wrq;
    byte_op = bq; reg_write = rw; rd = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 0;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_wb_data", wb_data, 0);
    reset = 1;
    step();

    // ALU pass-through
    issue(64'h2AA, 0, 0, 0, 0, 1, 5'd3);
    chk("add_stall_pre", stall, 0);
    step();
    idle_inputs();
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_data", wb_data, 64'h2AA);
    chk("add_wb_rd", wb_rd, 5'd3);
    chk("add_wb_rw", wb_reg_write, 1);
    chk("add_stall", stall, 0);
    step();
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_wb_hold", wb_data, 64'h2AA);

    // Ack while idle is ignored
    mem_ack = 1; mem_rdata = 64'h1234;
    step();
    idle_inputs();
    chk("idle_ack_wb_valid", wb_valid, 0);
    chk("idle_ack_stall", stall, 0);

    // LDUR, ack in third busy cycle
    issue(64'h40, 0, 1, 0, 0, 1, 5'd5);
    step();
    idle_inputs();
    chk("ldur_req_c1", mem_req, 1);
    chk("ldur_stall_c1", stall, 1);
    chk("ldur_addr", mem_addr, 64'h40);
    chk("ldur_we", mem_we, 0);
    step();
    chk("ldur_req_c2", mem_req, 1);
    step();
    chk("ldur_stall_c3", stall, 1);
    mem_ack = 1; mem_rdata = 64'h1122334455667788;
    step();
    idle_inputs();
    chk("ldur_req_done", mem_req, 0);
    chk("ldur_stall_done", stall, 0);
    chk("ldur_wb_valid", wb_valid, 1);
    chk("ldur_wb_data", wb_data, 64'h1122334455667788);
    chk("ldur_wb_rw", wb_reg_write, 1);
    chk("ldur_wb_rd", wb_rd, 5'd5);

    // LDURB at odd address, ack in first busy cycle
    issue(64'h43, 0, 1, 0, 1, 1, 5'd9);
    step();
    idle_inputs();
    chk("ldurb_req", mem_req, 1);
    chk("ldurb_byte", mem_byte, 1);
    chk("ldurb_err", mem_err, 0);
    mem_ack = 1; mem_rdata = 64'hFFFFFFFFFFFFFFA5;
    step();
    idle_inputs();
    chk("ldurb_wb_valid", wb_valid, 1);
    chk("ldurb_wb_data", wb_data, 64'hA5);
    chk("ldurb_wb_rd", wb_rd, 5'd9);
    chk("ldurb_err_after", mem_err, 0);

    // STUR aligned
    issue(64'h48, 64'hDEAD, 0, 1, 0, 0, 5'd0);
    step();
    idle_inputs();
    chk("stur_we", mem_we, 1);
    chk("stur_wdata", mem_wdata, 64'hDEAD);
    chk("stur_addr", mem_addr, 64'h48);
    mem_ack = 1;
    step();
    idle_inputs();
    chk("stur_wb_valid", wb_valid, 1);
    chk("stur_wb_rw", wb_reg_write, 0);
    chk("stur_wb_data_held", wb_data, 64'hA5);

    // STUR misaligned: no request, error
    issue(64'h44, 64'hBEEF, 0, 1, 0, 0, 5'd0);
    step();
    idle_inputs();
    chk("mis_req", mem_req, 0);
    chk("mis_stall", stall, 0);
    chk("mis_err", mem_err, 1);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_rw", wb_reg_write, 0);
    err_clr = 1;
    step();
    idle_inputs();
    chk("errclr", mem_err, 0);

    // Set wins over simultaneous clear
    issue(64'h41, 0, 1, 0, 0, 1, 5'd2);
    err_clr = 1;
    step();
    idle_inputs();
    chk("set_over_clr", mem_err, 1);
    chk("set_over_clr_rw", wb_reg_write, 0);
    err_clr = 1;
    step();
    idle_inputs();
    chk("errclr2", mem_err, 0);

    // Timeout: 16 busy cycles without ack
    issue(64'h80, 0, 1, 0, 0, 1, 5'd7);
    step();
    idle_inputs();
    for (int i = 0; i < 15; i++) begin
      chk("to_req_hold", mem_req, 1);
      step();
    end
    chk("to_req_last", mem_req, 1);
    step();
    chk("to_req_drop", mem_req, 0);
    chk("to_stall_drop", stall, 0);
    chk("to_err", mem_err, 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_rw", wb_reg_write, 0);
    err_clr = 1;
    step();
    idle_inputs();
    chk("to_errclr", mem_err, 0);

    // Ack on the 16th busy cycle beats the timeout
    issue(64'h88, 0, 1, 0, 0, 1, 5'd8);
    step();
    idle_inputs();
    for (int i = 0; i < 15; i++) step();
    chk("ack16_req_still", mem_req, 1);
    mem_ack = 1; mem_rdata = 64'hCAFEF00D12345678;
    step();
    idle_inputs();
    chk("ack16_err", mem_err, 0);
    chk("ack16_wb_valid", wb_valid, 1);
    chk("ack16_wb_data", wb_data, 64'hCAFEF00D12345678);
    chk("ack16_wb_rw", wb_reg_write, 1);
    chk("ack16_req", mem_req, 0);

    // Reset mid-BUSY with mem_err set
    issue(64'h3, 0, 1, 0, 0, 1, 5'd4);
    step();
    idle_inputs();
    chk("pre_rst_err", mem_err, 1);
    issue(64'h100, 0, 1, 0, 0, 1, 5'd6);
    step();
    idle_inputs();
    step();
    chk("pre_rst_req", mem_req, 1);
    reset = 0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_wb_valid", wb_valid, 0);
    chk("rst_mid_err", mem_err, 0);
    #1;
    reset = 1;
    mem_ack = 1; mem_rdata = 64'h5555;
    step();
    idle_inputs();
    chk("post_rst_wb_valid", wb_valid, 0);
    chk("post_rst_stall", stall, 0);
    issue(64'h77, 0, 0, 0, 0, 1, 5'd12);
    step();
    idle_inputs();
    chk("post_rst_add_valid", wb_valid, 1);
    chk("post_rst_add_data", wb_data, 64'h77);
    chk("post_rst_add_rd", wb_rd, 5'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined CPU. Sits directly downstream of the execute stage: it takes the ALU result, store data and memory controls produced there, performs loads and stores through a request/acknowledge data-memory port, stalls upstream while an access is outstanding, and delivers a registered result to write-back. It also detects misaligned 64-bit accesses and memory timeouts.

## Interface
- TIMEOUT, 16: maximum BUSY cycles waiting for mem_ack before abort (≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- ex_valid  in  1  execute stage presents an instruction this cycle
- alu_result  in  64  address for memory ops, result otherwise
- store_data  in  64  ReadData2 forwarded from execute
- mem_read  in  1  load (LDUR/LDURB)
- mem_write  in  1  store (STUR/STURB); never both with mem_read
- byte_op  in  1  byte-wide access (LDURB/STURB)
- reg_write  in  1  instruction writes a register
- rd  in  5  destination register
- err_clr  in  1  synchronous clear of mem_err
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write
- mem_byte  out  1  byte access
- mem_addr  out  64  access address
- mem_wdata  out  64  write data (byte store: bits 7:0 valid, upper bits as captured)
- mem_rdata  in  64  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- stall  out  1  upstream must hold its instruction
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_reg_write  out  1  write-back enable
- wb_rd  out  5  write-back register
- wb_data  out  64  write-back value
- mem_err  out  1  sticky error flag

## Operation
- States: IDLE, BUSY. Reset → IDLE; all outputs 0.
- IDLE, ex_valid=0: wb_valid=0 next cycle.
- IDLE, ex_valid=1, no memory op: next edge wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write. Stay IDLE.
- IDLE, ex_valid=1, memory op, misaligned (byte_op=0, alu_result[2:0]≠0): no request; next edge wb_valid=1, wb_reg_write=0, mem_err←1. Stay IDLE.
- IDLE, ex_valid=1, aligned memory op: capture address, data, mem_we=mem_write, mem_byte=byte_op, rd, reg_write; mem_req←1; timeout counter←0; → BUSY.
- BUSY: mem_req=1, stall=1, ex_valid ignored. Counter increments each cycle without ack.
- BUSY, mem_ack=1: mem_req←0; wb_valid←1; load: wb_data←mem_rdata (byte_op: zero-extended mem_rdata[7:0]), wb_reg_write←captured reg_write; store: wb_reg_write←0. → IDLE.
- BUSY, counter reaches TIMEOUT-1 with no ack: mem_req←0, wb_valid←1, wb_reg_write←0, mem_err←1, → IDLE.
- Ack and timeout same cycle: ack wins, no error.
- mem_ack in IDLE: ignored.
- mem_err: set by misalign/timeout, cleared by err_clr; set wins over simultaneous clear.
- Counter width: clog2(TIMEOUT); wraps never (reset on entry to BUSY).

## Timing
- stall combinational = (state==BUSY); low in IDLE.
- Non-memory and misaligned ops: 1-cycle latency, no stall; back-to-back acceptance every cycle.
- Memory op: accepted edge E0; mem_req high from E0; ack sampled at edge Ek; wb_valid high for cycle after Ek; stall low after Ek, next instruction accepted at Ek+1 edge.
- Minimum memory op occupancy: 2 edges (ack in first BUSY cycle).
- wb_* held between pulses; only wb_valid qualifies them.
- reset low mid-BUSY: mem_req, stall, wb_valid drop immediately; no write-back for aborted op; mem_err cleared.

## Test plan
- Reset then ex_valid, ADD result 0x2AA, rd=3, reg_write=1 → next cycle wb_valid=1, wb_data=0x2AA, wb_rd=3, stall never high.
- LDUR addr 0x40, ack after 3 BUSY cycles with rdata 0x1122334455667788 → mem_req/stall high 3 cycles, then wb_data=0x1122334455667788, wb_reg_write=1.
- LDURB addr 0x43, ack with rdata 0xFFFFFFFFFFFFFFA5 → wb_data=0x00000000000000A5; no misalign error.
- STUR addr 0x48 data 0xDEAD → mem_we=1, mem_wdata=0xDEAD; on ack wb_valid=1, wb_reg_write=0; STUR addr 0x44 → no mem_req, mem_err=1; err_clr → mem_err=0.
- Load with no ack (TIMEOUT=16) → mem_req drops after 16 BUSY cycles, mem_err=1, wb_reg_write=0; repeat with ack on cycle 16 → no error, data written back.
- Assert reset low mid-BUSY → mem_req, stall, wb_valid 0 immediately; after release, state IDLE and next ADD retires normally.
